cram_responder: RTL
===================

Name: cram_responder

Overview:
- Synthesizable device-side model of the asynchronous PSRAM on the cram interface, for simulation and on-FPGA loopback testing of the psram controller.
- Samples the controller's CE#/ADV#/WE#/OE#/LB#/UB# and address/data bus on the shared clock.
- Latches multiplexed addresses, stores writes in an internal word array and returns read data after a configurable OE# latency.
- Flags protocol violations.

Parameters:
- ADDRESS_BITS, 23: full word address width including bank bit; matches controller.
- DATA_BITS, 16: data bus width; low DATA_BITS address bits travel on the data bus.
- MEM_ADDR_BITS, 10: log2 of internal array depth (both banks combined).
- OE_LATENCY, 1: number of OE#-low cycles during which data is not yet valid.
- INVALID_PATTERN, 16'hDEAD: value on data_in whenever read data is not valid.

Ports:
- clk  input  1  system clock; controller runs on the same clock.
- reset_n  input  1  asynchronous active-low reset.
- cram  cram_if  —  device-side view.
  - Inputs: a, data_out, ce0_n, ce1_n, adv_n, oe_n, we_n, lb_n, ub_n, clk, cre.
  - Output: data_in.
- protocol_error  output  1  sticky violation flag; cleared only by reset.
- read_count  output  16  completed reads, wraps at 16'hFFFF -> 0.
- write_count  output  16  committed writes, wraps at 16'hFFFF -> 0.

Behaviour:
- Sampling:
  - All strobes are sampled at posedge clk.
  - ce_n = ce0_n & ce1_n; bank = ce0_n (1 when bank 1 is selected).
- Address and index:
  - Latched address = {bank, a, data_out}.
  - Array index = {bank, addr[MEM_ADDR_BITS-2:0]}; upper address bits are ignored, so addresses alias.
- States: IDLE, ADDR_RD, READ, ADDR_WR, WRITE.
- IDLE:
  - On ce_n=0, adv_n=0: latch the address and load rd_q <= mem[index].
  - Go to ADDR_WR if we_n=0, else ADDR_RD.
- ADDR_RD:
  - On ce_n=0, adv_n=1, oe_n=0: oe_cnt <= 1, go to READ.
  - On ce_n=0, adv_n=0: re-latch the address (restart).
  - On ce_n=1: go to IDLE.
- READ:
  - oe_cnt increments while oe_n=0, saturating at OE_LATENCY.
  - data_in = rd_q when oe_n=0 and oe_cnt has reached OE_LATENCY (combinational on oe_cnt), else INVALID_PATTERN.
  - With the default OE_LATENCY=1: the first OE#-low cycle shows INVALID_PATTERN; the second and later show data.
  - On ce_n=1: read_count++ if data was ever valid; go to IDLE.
- ADDR_WR and WRITE:
  - Each cycle with ce_n=0, we_n=0, adv_n=1: capture wr_q <= data_out and be_q <= {~ub_n, ~lb_n}; set pending. The last captured value wins.
  - On ce_n=1 with pending: write the enabled bytes of wr_q into mem[index], write_count++, go to IDLE. Without pending: IDLE, no write.
- Data bus: the controller drives the address cycle and then the data cycle; only the final data-phase cycle is committed.
- Reset values: state=IDLE, data_in=INVALID_PATTERN, protocol_error=0, read_count=0, write_count=0, pending=0, oe_cnt=0.
  - Array contents are not affected by reset; they are zero at time 0.
- protocol_error sets on any of:
  - ce0_n=0 and ce1_n=0 simultaneously;
  - oe_n=0 and we_n=0 simultaneously while selected;
  - oe_n=0 in IDLE or while adv_n=0;
  - we_n changes while ce_n=0 after the address phase;
  - cram.clk=1 or cre=1.
  - The offending cycle performs no array write; the FSM returns to IDLE when ce_n next goes high.
- Mid-operation events:
  - CE# deasserted during ADDR_WR before any data cycle: no write.
  - Reset asserted mid-write: pending is discarded and nothing is committed.
- Back-to-back: ce_n=1 for exactly one cycle between accesses is sufficient. Commit happens on the ce_n=1 cycle, so a read of the same address beginning on the next cycle returns the new data.

Test Plan:
- Controller write 23'h000123 <= 16'hBEEF, then read 23'h000123 -> rd_data=16'hBEEF; write_count=1, read_count=1; protocol_error=0.
- Write 23'h400005 <= 16'h1111 (bank 1) and 23'h000005 <= 16'h2222 (bank 0) -> reads return 16'h1111 and 16'h2222 respectively; ce1_n is used for the first access.
- Raw stimulus: OE# low for 3 cycles after an address phase with OE_LATENCY=1 -> data_in sequence DEAD, data, data.
- Raw stimulus: byte write with lb_n=0, ub_n=1, data 16'hABCD over stored 16'h1234 -> subsequent read returns 16'h12CD.
- Raw stimulus: drive ce0_n=ce1_n=0 for one cycle -> protocol_error=1 and stays 1; array unchanged; reset_n low clears it.
- Raw stimulus: assert reset_n low during the WRITE data cycle of 16'h5555 to address 7 -> address 7 keeps its old value; write_count=0.

Source files
------------

// File: rtl/cram_if.sv
// Controller <-> PSRAM pin bundle for the cram interface.
// Address phase drives a high bits on a and the low DATA_BITS on data_out.
interface cram_if #(
    parameter int ADDRESS_BITS = 23,
    parameter int DATA_BITS    = 16
);
    localparam int A_BITS = ADDRESS_BITS - DATA_BITS - 1;

    logic [A_BITS-1:0]    a;
    logic [DATA_BITS-1:0] data_out;
    logic [DATA_BITS-1:0] data_in;
    logic                 ce0_n;
    logic                 ce1_n;
    logic                 adv_n;
    logic                 oe_n;
    logic                 we_n;
    logic                 lb_n;
    logic                 ub_n;
    logic                 clk;
    logic                 cre;

    modport master (
        output a, data_out, ce0_n, ce1_n, adv_n, oe_n, we_n, lb_n, ub_n, clk, cre,
        input  data_in
    );

    modport slave (
        input  a, data_out, ce0_n, ce1_n, adv_n, oe_n, we_n, lb_n, ub_n, clk, cre,
        output data_in
    );
endinterface

// File: rtl/cram_responder.sv
// Device-side model of the asynchronous PSRAM: latches muxed addresses, stores
// byte-enabled writes, returns reads after an OE# latency and flags misuse.
module cram_responder #(
    parameter int                   ADDRESS_BITS    = 23,
    parameter int                   DATA_BITS       = 16,
    parameter int                   MEM_ADDR_BITS   = 10,
    parameter int                   OE_LATENCY      = 1,
    parameter logic [DATA_BITS-1:0] INVALID_PATTERN = 16'hDEAD
) (
    input  logic         clk,
    input  logic         reset_n,
    cram_if.slave        cram,
    output logic         protocol_error,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);
    localparam int DEPTH    = 1 << MEM_ADDR_BITS;
    localparam int OE_CNT_W = $clog2(OE_LATENCY + 1);
    localparam int HALF     = DATA_BITS / 2;

    typedef enum logic [2:0] {IDLE, ADDR_RD, READ, ADDR_WR, WRITE} state_t;

    state_t                   state, state_next;
    logic [DATA_BITS-1:0]     mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0] index_q;
    logic [MEM_ADDR_BITS-1:0] index_in;
    logic [DATA_BITS-1:0]     rd_q;
    logic [DATA_BITS-1:0]     wr_q;
    logic [1:0]               be_q;
    logic                     pending;
    logic                     rd_seen;
    logic [OE_CNT_W-1:0]      oe_cnt;

    logic ce_n, bank, data_valid, violation, wr_phase, rd_phase;
    logic load_addr, capture, commit, oe_start, oe_inc, rd_done;

    assign ce_n     = cram.ce0_n & cram.ce1_n;
    assign bank     = cram.ce0_n;
    // Only the bank bit and the low index bits select a word, so addresses alias.
    assign index_in = {bank, cram.data_out[MEM_ADDR_BITS-2:0]};
    assign wr_phase = state inside {ADDR_WR, WRITE};
    assign rd_phase = state inside {ADDR_RD, READ};

    assign data_valid    = (state == READ) && !ce_n && !cram.oe_n &&
                           (oe_cnt == OE_CNT_W'(OE_LATENCY));
    assign cram.data_in  = data_valid ? rd_q : INVALID_PATTERN;

    assign violation = (!cram.ce0_n && !cram.ce1_n)
                    || (!ce_n && !cram.oe_n && !cram.we_n)
                    || (state == IDLE && !cram.oe_n)
                    || (!ce_n && !cram.adv_n && !cram.oe_n)
                    || (!ce_n && cram.adv_n && wr_phase && cram.we_n)
                    || (!ce_n && cram.adv_n && rd_phase && !cram.we_n)
                    || cram.clk || cram.cre;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        oe_start   = 1'b0;
        oe_inc     = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!ce_n && !cram.adv_n) begin
                    load_addr  = 1'b1;
                    state_next = cram.we_n ? ADDR_RD : ADDR_WR;
                end
            end
            ADDR_RD: begin
                if (ce_n) begin
                    state_next = IDLE;
                end else if (!cram.adv_n) begin
                    load_addr = 1'b1;
                end else if (!cram.oe_n) begin
                    oe_start   = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (ce_n) begin
                    rd_done    = rd_seen;
                    state_next = IDLE;
                end else if (!cram.oe_n && oe_cnt != OE_CNT_W'(OE_LATENCY)) begin
                    oe_inc = 1'b1;
                end
            end
            ADDR_WR, WRITE: begin
                if (ce_n) begin
                    commit     = pending && !violation;
                    state_next = IDLE;
                end else if (!cram.adv_n) begin
                    load_addr = (state == ADDR_WR);
                end else if (!cram.we_n && !violation) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            protocol_error <= 1'b0;
            read_count     <= '0;
            write_count    <= '0;
            pending        <= 1'b0;
            rd_seen        <= 1'b0;
            oe_cnt         <= '0;
            index_q        <= '0;
            wr_q           <= '0;
            be_q           <= '0;
        end else begin
            state <= state_next;
            if (violation) protocol_error <= 1'b1;
            if (load_addr) begin
                index_q <= index_in;
                pending <= 1'b0;
                rd_seen <= 1'b0;
            end
            if (oe_start)    oe_cnt <= OE_CNT_W'(1);
            else if (oe_inc) oe_cnt <= oe_cnt + 1'b1;
            if (data_valid)  rd_seen <= 1'b1;
            if (capture) begin
                wr_q    <= cram.data_out;
                be_q    <= {~cram.ub_n, ~cram.lb_n};
                pending <= 1'b1;
            end else if (state_next == IDLE) begin
                pending <= 1'b0;
            end
            if (commit)  write_count <= write_count + 16'd1;
            if (rd_done) read_count  <= read_count + 16'd1;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a reset mid-write is safe
    // because the async reset forces IDLE, which blocks commit.
    always_ff @(posedge clk) begin
        if (load_addr) rd_q <= mem[index_in];
        if (commit) begin
            if (be_q[0]) mem[index_q][HALF-1:0]         <= wr_q[HALF-1:0];
            if (be_q[1]) mem[index_q][DATA_BITS-1:HALF] <= wr_q[DATA_BITS-1:HALF];
        end
    end
endmodule
